// File: rtl/div_16bit_seq_pkg.sv
// Shared definitions for the iterative divider: state encodings, widths and
// the fixed divide-by-zero quotient.
package div_16bit_seq_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned N_ITER    = 16;
    localparam int unsigned CNT_W     = 5;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_16bit_seq_add_sub.sv
// 16-bit adder/subtractor: sel=1 gives in0 - in1 with cout=1 meaning no borrow.
module add_sub_16bit (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        sel,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] operand_b;

    always_comb begin
        operand_b     = sel ? ~in1 : in1;
        {cout, sum}   = 17'({1'b0, in0}) + 17'({1'b0, operand_b}) + 17'(sel);
    end

endmodule

// File: rtl/div_16bit_seq.sv
// Restoring shift-subtract unsigned divider: one quotient bit per cycle,
// results registered on completion and held until the next accepted start.
module div_16bit_seq
    import div_16bit_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] q_q, q_d;
    logic [DIV_WIDTH-1:0] r_q, r_d;
    logic [DIV_WIDTH-1:0] d_q, d_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic                 dbz_q, dbz_d;

    logic                 shift_c;
    logic [DIV_WIDTH-1:0] shifted;
    logic [DIV_WIDTH-1:0] diff;
    logic                 no_borrow;

    // Partial remainder shifted left with the next dividend bit; shift_c is bit 16.
    assign shift_c = r_q[DIV_WIDTH-1];
    assign shifted = {r_q[DIV_WIDTH-2:0], q_q[DIV_WIDTH-1]};

    add_sub_16bit u_trial_sub (
        .in0  (shifted),
        .in1  (d_q),
        .sel  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (divisor != '0) begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        quotient_d  = DIV0_QUOTIENT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CALC: begin
                // A set shift_c means the 17-bit value exceeds any divisor.
                if (shift_c || no_borrow) begin
                    r_d = diff;
                    q_d = {q_q[DIV_WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted;
                    q_d = {q_q[DIV_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed bench for div_16bit_seq with a cycle-level behavioural model.
module tb_div_16bit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int n_chk  = 0;
    int n_fail = 0;
    int done_count = 0;

    div_16bit_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles left in the busy window, pending and visible results.
    int          m_left = 0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_z = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_q = '0; m_r = '0; m_z = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
                m_q = p_q; m_r = p_r; m_z = 1'b0;
            end
        end else if (start) begin
            if (divisor == 16'd0) begin
                m_left = 1;
                m_q = 16'hFFFF; m_r = dividend; m_z = 1'b1;
            end else begin
                m_left = 17;
                p_q = dividend / divisor;
                p_r = dividend % divisor;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_left == 1));
            chk("quotient", 32'(quotient), 32'(m_q));
            chk("remainder", 32'(remainder), 32'(m_r));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
            if (done) done_count++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one op, check latency from acceptance and the literal result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int exp_lat);
        int j = 0;
        wait_idle();
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = 16'hDEAD; divisor = 16'hBEEF;
        while (!done && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("latency", 32'(j), 32'(exp_lat));
        chk("lit_quotient", 32'(quotient), 32'(eq));
        chk("lit_remainder", 32'(remainder), 32'(er));
        chk("lit_div_by_zero", 32'(div_by_zero), 32'(ez));
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int dc0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        #11 rst = 1'b0;

        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        do_op(16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 16);
        do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
        do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
        do_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 16);
        do_op(16'h0003, 16'h0010, 16'd0, 16'd3, 1'b0, 16);
        repeat (20) @(negedge clk);
        chk("hold_quotient", 32'(quotient), 32'd0);
        chk("hold_remainder", 32'(remainder), 32'd3);

        // Start while busy must be ignored.
        dc0 = done_count;
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd7; divisor = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("ignored_quotient", 32'(quotient), 32'd100);
        chk("ignored_remainder", 32'(remainder), 32'd0);
        chk("single_done", 32'(done_count - dc0), 32'd1);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quotient", 32'(quotient), 32'd0);
        chk("arst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        do_op(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 16);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
